// File: rtl/xcvr_tx_gearbox_fifo.sv
// xcvr_tx_gearbox_fifo: show-ahead FIFO taking IN_WIDTH words and emitting IN_WIDTH/RATIO segments
module xcvr_tx_gearbox_fifo #(
  parameter int IN_WIDTH = 128,
  parameter int RATIO = 2,
  parameter int DEPTH = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter bit MSB_FIRST = 1'b0,
  localparam int OUT_WIDTH = IN_WIDTH / RATIO,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = $clog2(DEPTH * RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [IN_WIDTH-1:0]  data,
  input  logic                 wrreq,
  input  logic                 rdreq,
  output logic [OUT_WIDTH-1:0] q,
  output logic                 rdempty,
  output logic                 wrfull,
  output logic                 wralmostfull,
  output logic [AW:0]          wrusedw,
  output logic [RW-1:0]        rdusedw,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int SW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int CW = AW + 1;
  logic [IN_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] seg_q, seg_d, seg_idx;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic clr, wr_en, rd_en, last;
  logic [IN_WIDTH-1:0] head;
  assign wrusedw = wcnt_q;
  assign rdusedw = rcnt_q;
  assign wrfull = wcnt_q == CW'(DEPTH);
  assign rdempty = rcnt_q == '0;
  assign wralmostfull = int'(wcnt_q) >= AFULL_THRESH;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  always_comb begin
    clr = reset | flush;
    wr_en = wrreq & ~wrfull;
    rd_en = rdreq & ~rdempty;
    last = seg_q == SW'(RATIO - 1);
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(rd_en & last);
    seg_d = (clr || (rd_en && last)) ? '0 : seg_q + SW'(rd_en);
    wcnt_d = clr ? '0 : wcnt_q + CW'(wr_en) - CW'(rd_en & last);
    rcnt_d = clr ? '0 : rcnt_q + (wr_en ? RW'(RATIO) : '0) - RW'(rd_en);
    ovf_d = ~clr & (ovf_q | (wrreq & wrfull));
    unf_d = ~clr & (unf_q | (rdreq & rdempty));
    head = mem_q[rd_ptr_q];
    seg_idx = MSB_FIRST ? SW'(RATIO - 1) - seg_q : seg_q;
    q = rdempty ? '0 : head[seg_idx * OUT_WIDTH +: OUT_WIDTH];
  end
  always_ff @(posedge clk)
    if (wr_en && !clr) mem_q[wr_ptr_q] <= data;
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    seg_q <= seg_d;
    wcnt_q <= wcnt_d;
    rcnt_q <= rcnt_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end
endmodule

// File: tb/tb_xcvr_tx_gearbox_fifo.sv
// tb_xcvr_tx_gearbox_fifo: queue-model bench for both segment orders of the gearbox FIFO
module tb_xcvr_tx_gearbox_fifo;
  localparam int IW = 128;
  localparam int R = 2;
  localparam int D = 8;
  localparam int OW = IW / R;
  localparam int AF = D - 2;
  logic clk = 1'b0;
  logic reset, flush, wrreq, rdreq;
  logic [IW-1:0] data;
  logic [OW-1:0] q0, q1;
  logic rdempty0, rdempty1, wrfull0, wrfull1, af0, af1, ovf0, ovf1, unf0, unf1;
  logic [3:0] wru0, wru1;
  logic [4:0] rdu0, rdu1;
  int checks = 0;
  int errors = 0;
  bit chk = 1'b0;
  logic [IW-1:0] mw [$];
  int hd = 0;
  bit movf = 1'b0;
  bit munf = 1'b0;
  int maxw = 0;
  always #5 clk = ~clk;
  xcvr_tx_gearbox_fifo #(.IN_WIDTH(IW), .RATIO(R), .DEPTH(D), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q0), .rdempty(rdempty0), .wrfull(wrfull0), .wralmostfull(af0), .wrusedw(wru0),
    .rdusedw(rdu0), .overflow(ovf0), .underflow(unf0));
  xcvr_tx_gearbox_fifo #(.IN_WIDTH(IW), .RATIO(R), .DEPTH(D), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q1), .rdempty(rdempty1), .wrfull(wrfull1), .wralmostfull(af1), .wrusedw(wru1),
    .rdusedw(rdu1), .overflow(ovf1), .underflow(unf1));
  function automatic logic [OW-1:0] seg(input logic [IW-1:0] w, input int k);
    return w[k*OW +: OW];
  endfunction
  function automatic int m_rdu();
    return mw.size() * R - hd;
  endfunction
  task automatic chk_val(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (chk) begin
    chk_val("wrusedw0", IW'(wru0), IW'(mw.size()));
    chk_val("wrusedw1", IW'(wru1), IW'(mw.size()));
    chk_val("rdusedw0", IW'(rdu0), IW'(m_rdu()));
    chk_val("rdusedw1", IW'(rdu1), IW'(m_rdu()));
    chk_val("rdempty0", IW'(rdempty0), IW'(m_rdu() == 0));
    chk_val("rdempty1", IW'(rdempty1), IW'(m_rdu() == 0));
    chk_val("wrfull0", IW'(wrfull0), IW'(mw.size() == D));
    chk_val("wrfull1", IW'(wrfull1), IW'(mw.size() == D));
    chk_val("afull0", IW'(af0), IW'(mw.size() >= AF));
    chk_val("overflow0", IW'(ovf0), IW'(movf));
    chk_val("overflow1", IW'(ovf1), IW'(movf));
    chk_val("underflow0", IW'(unf0), IW'(munf));
    chk_val("underflow1", IW'(unf1), IW'(munf));
    if (m_rdu() > 0) begin
      chk_val("q0", IW'(q0), IW'(seg(mw[0], hd)));
      chk_val("q1", IW'(q1), IW'(seg(mw[0], R - 1 - hd)));
    end
    if (int'(wru0) > maxw) maxw = int'(wru0);
  end
  task automatic cyc(input bit wr, input bit rd, input logic [IW-1:0] d, input bit fl, input bit rs);
    bit full, empty;
    wrreq = wr;
    rdreq = rd;
    data = d;
    flush = fl;
    reset = rs;
    @(posedge clk);
    full = mw.size() == D;
    empty = m_rdu() == 0;
    if (rs || fl) begin
      mw.delete();
      hd = 0;
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      if (wr && full) movf = 1'b1;
      if (rd && empty) munf = 1'b1;
      if (rd && !empty) begin
        hd++;
        if (hd == R) begin
          void'(mw.pop_front());
          hd = 0;
        end
      end
      if (wr && !full) mw.push_back(d);
    end
    @(negedge clk);
  endtask
  function automatic logic [IW-1:0] mk(input int i);
    return {64'(2 * i + 1), 64'(2 * i)};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    int i, n;
    bit full;
    logic [IW-1:0] w0, wn;
    w0 = {64'h1111111111111111, 64'h2222222222222222};
    wn = {64'hAAAA0000BBBB0001, 64'hCCCC0002DDDD0003};
    @(negedge clk);
    cyc(1, 1, '1, 1, 1);
    chk = 1'b1;
    chk_val("rst_rdempty", IW'(rdempty0), IW'(1));
    chk_val("rst_wrusedw", IW'(wru0), IW'(0));
    chk_val("rst_q", IW'(q0), IW'(0));
    chk_val("rst_afull", IW'(af0), IW'(0));
    cyc(1, 0, w0, 0, 0);
    chk_val("lsb_first_q", IW'(q0), IW'(64'h2222222222222222));
    chk_val("msb_first_q", IW'(q1), IW'(64'h1111111111111111));
    chk_val("rdusedw_2", IW'(rdu0), IW'(2));
    cyc(0, 1, '0, 0, 0);
    chk_val("lsb_second_q", IW'(q0), IW'(64'h1111111111111111));
    chk_val("msb_second_q", IW'(q1), IW'(64'h2222222222222222));
    chk_val("wrusedw_hold", IW'(wru0), IW'(1));
    cyc(0, 1, '0, 0, 0);
    chk_val("empty_after_2", IW'(rdempty0), IW'(1));
    cyc(0, 1, '0, 0, 0);
    chk_val("underflow_set", IW'(unf0), IW'(1));
    chk_val("underflow_rdusedw", IW'(rdu0), IW'(0));
    cyc(0, 0, '0, 1, 0);
    chk_val("flush_underflow", IW'(unf0), IW'(0));
    for (int k = 0; k < D; k++) cyc(1, 0, mk(500 + k), 0, 0);
    chk_val("full_8", IW'(wrfull0), IW'(1));
    cyc(1, 1, mk(999), 0, 0);
    chk_val("ovf_full", IW'(wrfull0), IW'(1));
    chk_val("ovf_set", IW'(ovf0), IW'(1));
    chk_val("ovf_wrusedw", IW'(wru0), IW'(8));
    chk_val("ovf_rdusedw", IW'(rdu0), IW'(15));
    n = 0;
    while (m_rdu() > 0 && n < 100) begin cyc(0, 1, '0, 0, 0); n++; end
    cyc(0, 0, '0, 1, 0);
    maxw = 0;
    cyc(1, 0, mk(0), 0, 0);
    i = 1;
    n = 0;
    while (i < 100 && n < 2000) begin
      full = mw.size() == D;
      cyc(1, 1, mk(i), 0, 0);
      if (!full) i++;
      n++;
    end
    n = 0;
    while (m_rdu() > 0 && n < 300) begin cyc(0, 1, '0, 0, 0); n++; end
    chk_val("stream_done", IW'(i), IW'(100));
    chk_val("stream_drained", IW'(rdempty0), IW'(1));
    chk_val("stream_max_wrusedw", IW'(maxw <= D), IW'(1));
    cyc(0, 0, '0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, mk(700 + k), 0, 0);
    cyc(0, 1, '0, 0, 0);
    cyc(1, 1, mk(800), 1, 1);
    chk_val("rst2_rdempty", IW'(rdempty0), IW'(1));
    chk_val("rst2_wrfull", IW'(wrfull0), IW'(0));
    chk_val("rst2_wrusedw", IW'(wru0), IW'(0));
    chk_val("rst2_rdusedw", IW'(rdu0), IW'(0));
    chk_val("rst2_ovf_unf", IW'({ovf0, unf0}), IW'(0));
    chk_val("rst2_q", IW'(q0), IW'(0));
    cyc(1, 0, wn, 0, 0);
    chk_val("new_q_lo", IW'(q0), IW'(64'hCCCC0002DDDD0003));
    cyc(0, 1, '0, 0, 0);
    chk_val("new_q_hi", IW'(q0), IW'(64'hAAAA0000BBBB0001));
    cyc(0, 1, '0, 0, 0);
    chk_val("new_empty", IW'(rdempty0), IW'(1));
    chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
